// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC, runs the imem req/ack handshake,
// presents fetched words to decode and squashes wrong-path fetches on redirect.
module fetch_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [31:0] PC_STEP    = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] boot_addr,
  input  logic        stall_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        flush_d,
  output logic        misaligned
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t      state;
  state_t      next_state;
  logic        pend;
  logic [31:0] pend_target;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] redirect_target;

  // Exception beats jump beats branch; the stored target is always word aligned.
  always_comb begin
    redirect   = exception | jump | branch_taken;
    raw_target = branch_target;
    if (exception)
      raw_target = EXC_VECTOR;
    else if (jump)
      raw_target = jump_target;
    redirect_target = {raw_target[31:2], 2'b00};
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= BOOT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT: next_state = REQ;
      REQ:  if (imem_req && imem_ack && !redirect && !pend && stall_d)
              next_state = HOLD;
      HOLD: if (redirect || !stall_d)
              next_state = REQ;
      default: next_state = BOOT;
    endcase
  end

  // The cycle right after a delivered word (fetch_valid high in REQ) issues no
  // request, which gives the 1-per-2-cycles streaming rate.
  always_comb begin
    imem_req  = (state == REQ) && !fetch_valid;
    imem_addr = pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= '0;
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
      flush_d     <= 1'b0;
      misaligned  <= 1'b0;
      pend        <= 1'b0;
      pend_target <= '0;
    end else begin
      flush_d <= (state != BOOT) && redirect;
      if ((state != BOOT) && redirect && (raw_target[1:0] != 2'b00))
        misaligned <= 1'b1;
      case (state)
        BOOT: begin
          pc          <= boot_addr & ~32'd3;
          fetch_valid <= 1'b0;
        end
        REQ: begin
          if (!imem_req) begin
            fetch_valid <= 1'b0;
            if (redirect)
              pc <= redirect_target;
          end else if (imem_ack) begin
            // A word acked after (or alongside) a redirect is from the wrong path.
            if (redirect || pend) begin
              pc   <= redirect ? redirect_target : pend_target;
              pend <= 1'b0;
            end else begin
              fetch_valid <= 1'b1;
              fetch_pc    <= pc;
              if (!stall_d)
                pc <= pc + PC_STEP;
            end
          end else if (redirect) begin
            pend        <= 1'b1;
            pend_target <= redirect_target;
          end
        end
        HOLD: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            pc          <= redirect_target;
          end else if (!stall_d) begin
            fetch_valid <= 1'b0;
            pc          <= pc + PC_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
